// File: rtl/fifo_sched_pkg.sv
// Shared types, default sizing and helpers for the FIFO access scheduler.
// Controller-side widths are derived from the instance parameters through the helper functions.
package fifo_sched_pkg;

    localparam int N_REQ_DEF        = 4;
    localparam int WIDTH_DEF        = 8;
    localparam int CAPACITY_DEF     = 7;
    localparam int MAX_RD_BURST_DEF = 4;

    localparam int CNT_W = $clog2(CAPACITY_DEF + 1);
    localparam int IDX_W = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } fifo_op_e;

    function automatic int cnt_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Bit offset of producer idx's word inside the packed data_in bus.
    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fifo_access_scheduler_rr_picker.sv
// Combinational round-robin picker: first eligible index after ptr_i, wrapping modulo N.
module rr_picker
    import fifo_sched_pkg::*;
#(
    parameter int N        = N_REQ_DEF,
    parameter int IDX_BITS = IDX_W
)(
    input  logic [N-1:0]        elig_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic [IDX_BITS-1:0] grant_o,
    output logic                valid_o
);

    logic [IDX_BITS-1:0] cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest eligible one is kept.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_BITS'((int'(ptr_i) + k) % N);
            if (elig_i[cand]) begin
                grant_o = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Time-shares one FIFO port between N_REQ round-robin producers and one consumer.
// Reads win over writes until MAX_RD_BURST back-to-back reads, then one pending write is forced in.
module fifo_access_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CAPACITY     = CAPACITY_DEF,
    parameter int MAX_RD_BURST = MAX_RD_BURST_DEF
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*WIDTH-1:0]          data_in,
    output logic [N_REQ-1:0]                ack,
    input  logic                            rd_req,
    output logic [WIDTH-1:0]                rd_data,
    output logic                            rd_valid,
    output logic                            fifo_w,
    output logic                            fifo_r,
    output logic [WIDTH-1:0]                fifo_data,
    input  logic [WIDTH-1:0]                fifo_q,
    output logic [$clog2(CAPACITY+1)-1:0]   count,
    output logic                            full,
    output logic                            empty
);

    localparam int CNT_BITS = cnt_width(CAPACITY);
    localparam int IDX_BITS = idx_width(N_REQ);
    localparam int BST_BITS = $clog2(MAX_RD_BURST + 1);

    logic [WIDTH-1:0]    words [N_REQ];
    logic [N_REQ-1:0]    eligible;
    logic [IDX_BITS-1:0] grant;
    logic                any_wr;
    logic                burst_sat;
    logic                do_rd;
    logic                do_wr;

    fifo_op_e            op_q, op_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]    fifo_data_q, fifo_data_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [BST_BITS-1:0] burst_q, burst_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic                rd_pipe_q;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    rd_data_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
        assign words[gi] = data_in[word_lsb(gi, WIDTH) +: WIDTH];
    end

    // A producer acked last cycle still shows req; masking it prevents a double write.
    assign eligible = req & ~ack_q;

    rr_picker #(
        .N        (N_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_picker (
        .elig_i  (eligible),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .valid_o (any_wr)
    );

    assign full      = (cnt_q == CNT_BITS'(CAPACITY));
    assign empty     = (cnt_q == '0);
    assign burst_sat = (burst_q == BST_BITS'(MAX_RD_BURST));
    assign do_rd     = rd_req & ~empty & ~(burst_sat & any_wr & ~full);
    assign do_wr     = ~do_rd & any_wr & ~full;

    always_comb begin
        op_d        = OP_IDLE;
        ack_d       = '0;
        fifo_data_d = fifo_data_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        burst_d     = '0;
        if (do_rd) begin
            op_d    = OP_READ;
            cnt_d   = cnt_q - CNT_BITS'(1);
            burst_d = burst_sat ? burst_q : burst_q + BST_BITS'(1);
        end else if (do_wr) begin
            op_d        = OP_WRITE;
            ack_d       = N_REQ'(1) << grant;
            fifo_data_d = words[grant];
            cnt_d       = cnt_q + CNT_BITS'(1);
            ptr_d       = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_IDLE;
            ack_q       <= '0;
            fifo_data_q <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
            ptr_q       <= IDX_BITS'(N_REQ - 1);
            rd_pipe_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            op_q        <= op_d;
            ack_q       <= ack_d;
            fifo_data_q <= fifo_data_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            ptr_q       <= ptr_d;
            // The FIFO presents DataO the cycle after R; capture it one edge later.
            rd_pipe_q   <= (op_q == OP_READ);
            rd_valid_q  <= rd_pipe_q;
            if (rd_pipe_q) begin
                rd_data_q <= fifo_q;
            end
        end
    end

    assign fifo_w    = (op_q == OP_WRITE);
    assign fifo_r    = (op_q == OP_READ);
    assign ack       = ack_q;
    assign fifo_data = fifo_data_q;
    assign count     = cnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Bench for fifo_access_scheduler: behavioural FIFO, queue-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_fifo_access_scheduler;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CAP  = 7;
    localparam int MAXB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic           rd_req = 1'b0;
    logic [N-1:0]   ack;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           fifo_w;
    logic           fifo_r;
    logic [W-1:0]   fifo_data;
    logic [W-1:0]   fifo_q = '0;
    logic [2:0]     count;
    logic           full;
    logic           empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_access_scheduler #(
        .N_REQ(N), .WIDTH(W), .CAPACITY(CAP), .MAX_RD_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_w(fifo_w), .fifo_r(fifo_r), .fifo_data(fifo_data), .fifo_q(fifo_q),
        .count(count), .full(full), .empty(empty)
    );

    // Attached FIFO: registered DataO, re-initialised together with the controller.
    logic [W-1:0] fmem [CAP+1];
    logic [2:0]   fwp = '0;
    logic [2:0]   frp = '0;
    int           focc = 0;
    logic         fifo_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp  <= '0;
            frp  <= '0;
            focc <= 0;
        end else if (fifo_w) begin
            if (focc >= CAP) fifo_err <= 1'b1;
            fmem[fwp] <= fifo_data;
            fwp       <= fwp + 3'd1;
            focc      <= focc + 1;
        end else if (fifo_r) begin
            if (focc == 0) fifo_err <= 1'b1;
            fifo_q <= fmem[frp];
            frp    <= frp + 3'd1;
            focc   <= focc - 1;
        end
    end

    // Reference model
    typedef struct { int due; logic [W-1:0] d; } rd_t;
    int           m_cnt, m_ptr, m_burst;
    logic [N-1:0] m_ack;
    logic         m_w, m_r, m_rdv;
    logic [W-1:0] m_data, m_rd_data;
    logic [W-1:0] m_words [$];
    rd_t          m_pipe [$];
    int           edge_n = 0;

    int           grant_log [$];
    int           op_log [$];
    int           rdv_cyc [$];
    logic [W-1:0] rdv_dat [$];

    task automatic model_reset();
        m_cnt = 0; m_ptr = N - 1; m_burst = 0; m_ack = '0;
        m_w = 1'b0; m_r = 1'b0; m_rdv = 1'b0; m_data = '0; m_rd_data = '0;
        m_words.delete();
        m_pipe.delete();
    endtask

    task automatic model_edge();
        int g;
        bit do_rd, do_wr, m_full;
        logic [N-1:0] el;
        rd_t e;
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        el = req & ~m_ack;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && ((el >> i) & N'(1)) != '0) g = i;
        end
        m_full = (m_cnt == CAP);
        do_rd  = rd_req && (m_cnt > 0) && !(m_burst == MAXB && g >= 0 && !m_full);
        do_wr  = !do_rd && g >= 0 && !m_full;
        m_rdv = 1'b0;
        if (m_pipe.size() > 0 && m_pipe[0].due == edge_n) begin
            m_rdv     = 1'b1;
            m_rd_data = m_pipe[0].d;
            m_pipe.delete(0);
        end
        m_ack = '0;
        m_w   = do_wr;
        m_r   = do_rd;
        if (do_wr) begin
            m_data = W'(data_in >> (g * W));
            m_ack  = N'(1) << g;
            m_words.push_back(m_data);
            m_ptr  = g;
            m_cnt++;
        end
        if (do_rd) begin
            e.due = edge_n + 2;
            e.d   = m_words.pop_front();
            m_pipe.push_back(e);
            m_cnt--;
        end
        m_burst = do_rd ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("ack",      32'(ack),      32'(m_ack));
        check("fifo_w",   32'(fifo_w),   32'(m_w));
        check("fifo_r",   32'(fifo_r),   32'(m_r));
        check("rd_valid", 32'(rd_valid), 32'(m_rdv));
        check("rd_data",  32'(rd_data),  32'(m_rd_data));
        check("count",    32'(count),    32'(m_cnt));
        check("full",     32'(full),     32'(m_cnt == CAP));
        check("empty",    32'(empty),    32'(m_cnt == 0));
        if (m_w) check("fifo_data", 32'(fifo_data), 32'(m_data));
        check("w_r_exclusive", 32'(fifo_w & fifo_r), 32'(0));
        check("fifo_over_under", 32'(fifo_err), 32'(0));
        for (int i = 0; i < N; i++) if (ack[i]) grant_log.push_back(i);
        if (fifo_r) op_log.push_back(1);
        if (fifo_w) op_log.push_back(2);
        if (rd_valid) begin
            rdv_cyc.push_back(edge_n);
            rdv_dat.push_back(rd_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_ack"},       32'(ack),       32'(0));
        check({tag, "_fifo_w"},    32'(fifo_w),    32'(0));
        check({tag, "_fifo_r"},    32'(fifo_r),    32'(0));
        check({tag, "_rd_valid"},  32'(rd_valid),  32'(0));
        check({tag, "_fifo_data"}, 32'(fifo_data), 32'(0));
        check({tag, "_rd_data"},   32'(rd_data),   32'(0));
        check({tag, "_count"},     32'(count),     32'(0));
        check({tag, "_empty"},     32'(empty),     32'(1));
        check({tag, "_full"},      32'(full),      32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        reset_literals("reset");
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input int i, input logic [W-1:0] d);
        data_in[i*W +: W] = d;
        req[i] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (ack[i]) break;
        end
        check("write_ack", 32'(ack[i]), 32'(1));
        req[i] = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd_req = 1'b1;
        repeat (n) tick();
        rd_req = 1'b0;
        repeat (5) tick();
    endtask

    int exp_g   [7] = '{0, 1, 2, 3, 0, 1, 2};
    int exp_ops [7] = '{1, 1, 1, 1, 2, 1, 1};
    int start;

    initial begin
        model_reset();
        #1;
        do_reset();

        // Single producer write lands in the cycle after the request
        data_in[7:0] = 8'h11;
        req = 4'b0001;
        tick();
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_fifo_w", 32'(fifo_w), 32'h1);
        check("t1_fifo_data", 32'(fifo_data), 32'h11);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        req = '0;
        read_n(1);

        // All producers held: round-robin order until full
        do_reset();
        data_in = {8'h23, 8'h22, 8'h21, 8'h20};
        req = 4'b1111;
        grant_log.delete();
        repeat (12) tick();
        check("t2_grants", 32'(grant_log.size()), 32'd7);
        for (int k = 0; k < 7 && k < grant_log.size(); k++)
            check("t2_grant_order", 32'(grant_log[k]), 32'(exp_g[k]));
        check("t2_count", 32'(count), 32'd7);
        check("t2_full", 32'(full), 32'd1);
        req = '0;
        read_n(7);
        check("t2_empty", 32'(empty), 32'd1);

        // Read latency and ordering
        write_word(0, 8'hA0);
        write_word(0, 8'hA1);
        write_word(0, 8'hA2);
        rdv_cyc.delete();
        rdv_dat.delete();
        start = edge_n;
        rd_req = 1'b1;
        repeat (3) tick();
        rd_req = 1'b0;
        repeat (5) tick();
        check("t3_rdv_count", 32'(rdv_cyc.size()), 32'd3);
        for (int k = 0; k < 3 && k < rdv_cyc.size(); k++) begin
            check("t3_rdv_latency", 32'(rdv_cyc[k] - start), 32'(3 + k));
            check("t3_rdv_data", 32'(rdv_dat[k]), 32'(8'hA0 + k));
        end
        check("t3_empty", 32'(empty), 32'd1);

        // Write-starvation guard after a read burst
        for (int k = 0; k < 5; k++) write_word(1, 8'(8'hB0 + k));
        check("t4_count", 32'(count), 32'd5);
        data_in[2*W +: W] = 8'hC2;
        req[2] = 1'b1;
        rd_req = 1'b1;
        op_log.delete();
        grant_log.delete();
        for (int t = 0; t < 20; t++) begin
            tick();
            if (ack[2]) break;
        end
        check("t4_ack2", 32'(ack[2]), 32'd1);
        req[2] = 1'b0;
        repeat (3) tick();
        rd_req = 1'b0;
        repeat (5) tick();
        check("t4_ops", 32'(op_log.size()), 32'd7);
        for (int k = 0; k < 7 && k < op_log.size(); k++)
            check("t4_op_seq", 32'(op_log[k]), 32'(exp_ops[k]));
        if (grant_log.size() > 0) check("t4_grant", 32'(grant_log[0]), 32'd2);
        else check("t4_grant_seen", 32'(grant_log.size()), 32'd1);

        // Read request while empty
        check("t5_empty_before", 32'(empty), 32'd1);
        rd_req = 1'b1;
        repeat (5) begin
            tick();
            check("t5_fifo_r", 32'(fifo_r), 32'd0);
            check("t5_rd_valid", 32'(rd_valid), 32'd0);
            check("t5_count", 32'(count), 32'd0);
        end
        rd_req = 1'b0;
        repeat (4) tick();

        // Asynchronous reset mid-stream with requests pending
        for (int k = 0; k < 4; k++) write_word(3, 8'(8'hD0 + k));
        check("t6_count", 32'(count), 32'd4);
        data_in = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        req = 4'b1111;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        reset_literals("t6_async");
        tick();
        rst = 1'b0;
        tick();
        check("t6_first_ack", 32'(ack), 32'h1);
        check("t6_first_data", 32'(fifo_data), 32'hE0);
        req = '0;
        repeat (3) tick();
        read_n(1);
        check("t6_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_access_scheduler.md
Name: fifo_access_scheduler

Overview:
Shares one single-port-per-cycle FIFO instance between N_REQ producers and one consumer. The FIFO never performs a read and a write in the same cycle, and read has priority. Round-robin arbitration among producers, read-priority scheduling with a write-starvation guard. Occupancy tracking generates full/empty locally, so the FIFO is never written when full or read when empty. Sits directly in front of the FIFO: drives its W, R and DataI, and captures its DataO.

Parameters:
N_REQ, 4, number of producer ports (2..8)
WIDTH, 8, data width; must equal the FIFO Width
CAPACITY, 7, maximum entries the attached FIFO holds (FIFO Depth-1)
MAX_RD_BURST, 4, consecutive reads allowed before a pending write is forced in

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  producer i requests a write; held with its data until ack[i]
data_in  in  N_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH]
ack  out  N_REQ  one-cycle pulse; producer i's word is written this cycle
rd_req  in  1  consumer requests one word (level; one read per accepted cycle)
rd_data  out  WIDTH  word read from the FIFO
rd_valid  out  1  one-cycle pulse; rd_data valid
fifo_w  out  1  to FIFO W
fifo_r  out  1  to FIFO R
fifo_data  out  WIDTH  to FIFO DataI
fifo_q  in  WIDTH  from FIFO DataO
count  out  $clog2(CAPACITY+1)  committed occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0

Behaviour:
- Reset (async, immediate): ack=0, fifo_w=0, fifo_r=0, rd_valid=0, fifo_data=0, rd_data=0, count=0, empty=1, full=0. RR pointer points to N_REQ-1, so requester 0 has first priority. burst counter=0.
- The FIFO has no reset of its own. The controller must be reset together with FIFO re-initialisation. No drain is attempted.
- Decision in cycle c, registered at edge c→c+1. Outputs are valid in cycle c+1:
  - do_rd = rd_req & !empty & !(burst==MAX_RD_BURST & any_wr_eligible & !full)
  - do_wr = !do_rd & any_wr_eligible & !full
- Eligible producer: req[i]=1 and ack[i]=0 in cycle c. This masks the requester just acked, so it cannot be written twice for one word. A producer holding req continuously gets at most every other cycle.
- Round-robin grant: search starts at pointer+1 modulo N_REQ; the first eligible index wins. The pointer updates to the winner only on do_wr.
- On do_wr: fifo_w=1, fifo_data=data_in[g], ack[g]=1, all in cycle c+1. count increments at the same edge.
- On do_rd: fifo_r=1 in cycle c+1. count decrements at the same edge. rd_data captures fifo_q at the end of c+2, and rd_valid=1 in cycle c+3. Total latency rd_req→rd_valid is 3 cycles.
- fifo_w and fifo_r are never both 1, and neither is held for more than one cycle per operation.
- Burst counter:
  - increments on do_rd and saturates at MAX_RD_BURST
  - clears on do_wr, or on any cycle with no read
  - at saturation, a read loses to an eligible write if not full
- full and empty are combinational from the registered count. count never exceeds CAPACITY and never underflows. If rd_req arrives while empty, nothing is issued and no rd_valid is produced; the consumer retries.
- Simultaneous read and write requests: read wins (subject to the guard). The producer keeps req and is served later.
- count width arithmetic: unsigned, no wrap. Grant index is $clog2(N_REQ) bits.

Decomposition:
- Package fifo_sched_pkg holds localparams CNT_W = $clog2(CAPACITY+1) and IDX_W = $clog2(N_REQ), plus the data_in slice helper function.
- One sub-module: rr_picker. It is combinational; inputs are eligible mask and pointer, outputs are grant index and valid. It is instantiated once.

Test Plan:
- Reset, then req=4'b0001 with data 0x11 → ack[0] and fifo_w in cycle 2 with fifo_data=0x11; count=1, empty=0.
- req=4'b1111 held, rd_req=0 → grants in order 0,1,2,3,0,1,2; count reaches 7 and full=1; no further fifo_w while req stays high.
- Fill 3 words (0xA0,0xA1,0xA2), then rd_req=1 for 3 cycles → rd_valid pulses carry 0xA0,0xA1,0xA2, each 3 cycles after its rd_req cycle; empty=1 after.
- count=5, rd_req held high and req[2]=1 → 4 consecutive fifo_r, then one fifo_w with ack[2]. fifo_r and fifo_w are never high together.
- rd_req=1 while empty → fifo_r stays 0 and rd_valid stays 0; count stays 0.
- Assert rst mid-stream with count=4 and req pending → all outputs zero immediately; after release, requester 0 is served first.
